// File: rtl/alarm_bank.sv
// Multi-slot alarm store with change-detect trigger and ring/snooze/dismiss FSM.
// Ports: clk, rst_n, tick_1hz, clock_time, slot write/toggle controls,
//        snooze/dismiss buttons; outputs slot times/enables, ring state, ring_id, snooze_left.
module alarm_bank #(
    parameter int NUM_ALARMS = 4,
    parameter int TIME_W     = 24,
    parameter int SNOOZE_SEC = 540,
    parameter int RING_SEC   = 60,
    parameter int MAX_SNOOZE = 3,
    localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
    localparam int SNZ_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tick_1hz,
    input  logic [TIME_W-1:0]            clock_time,
    input  logic                         load_alarm,
    input  logic [SEL_W-1:0]             load_sel,
    input  logic                         load_src,
    input  logic [TIME_W-1:0]            load_value,
    input  logic                         toggle_en,
    input  logic                         snooze,
    input  logic                         dismiss,
    output logic [NUM_ALARMS*TIME_W-1:0] alarm_times,
    output logic [NUM_ALARMS-1:0]        alarm_en,
    output logic                         ringing,
    output logic                         snoozed,
    output logic [SEL_W-1:0]             ring_id,
    output logic [SNZ_W-1:0]             snooze_left
);

    localparam int RC_W = $clog2(RING_SEC + 1);
    localparam int SC_W = $clog2(SNOOZE_SEC + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   times_q [NUM_ALARMS];
    logic [TIME_W-1:0]   times_d [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] en_q, en_d;
    logic [TIME_W-1:0]   prev_q;
    logic [RC_W-1:0]     ring_cnt_q, ring_cnt_d;
    logic [SC_W-1:0]     snz_cnt_q, snz_cnt_d;
    logic [SNZ_W-1:0]    left_q, left_d;
    logic [SEL_W-1:0]    id_q, id_d;
    logic                sel_ok;
    logic                hit;
    logic [SEL_W-1:0]    hit_id;

    // Slot writes; a load overrides a same-cycle toggle.
    always_comb begin
        en_d    = en_q;
        times_d = times_q;
        sel_ok  = 32'(load_sel) < NUM_ALARMS;
        if (sel_ok) begin
            if (toggle_en)
                en_d[load_sel] = ~en_q[load_sel];
            if (load_alarm) begin
                en_d[load_sel]    = 1'b1;
                times_d[load_sel] = load_src ? load_value : clock_time;
            end
        end
    end

    // Fires only on the cycle clock_time arrives; lowest index wins.
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (en_q[i] && clock_time == times_q[i] &&
                clock_time != prev_q) begin
                hit    = 1'b1;
                hit_id = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        left_d     = left_q;
        id_d       = id_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d    = RINGING;
                    id_d       = hit_id;
                    ring_cnt_d = '0;
                    left_d     = SNZ_W'(MAX_SNOOZE);
                end
            end
            RINGING: begin
                // Losing the slot enable (next-cycle value) aborts the alarm.
                if (!en_d[id_q] || dismiss) begin
                    state_d = IDLE;
                end else if (snooze && left_q != '0) begin
                    state_d   = SNOOZED;
                    snz_cnt_d = SC_W'(SNOOZE_SEC);
                    left_d    = left_q - 1'b1;
                end else if (snooze) begin
                    state_d = IDLE;
                end else if (tick_1hz) begin
                    if (ring_cnt_q == RC_W'(RING_SEC - 1))
                        state_d = IDLE;
                    else
                        ring_cnt_d = ring_cnt_q + 1'b1;
                end
            end
            SNOOZED: begin
                if (!en_d[id_q] || dismiss) begin
                    state_d = IDLE;
                end else if (tick_1hz) begin
                    if (snz_cnt_q == SC_W'(1)) begin
                        state_d    = RINGING;
                        ring_cnt_d = '0;
                    end else begin
                        snz_cnt_d = snz_cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            en_q       <= '0;
            prev_q     <= '0;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            left_q     <= SNZ_W'(MAX_SNOOZE);
            id_q       <= '0;
            ringing    <= 1'b0;
            snoozed    <= 1'b0;
            for (int i = 0; i < NUM_ALARMS; i++)
                times_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            prev_q     <= clock_time;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            left_q     <= left_d;
            id_q       <= id_d;
            ringing    <= (state_d == RINGING);
            snoozed    <= (state_d == SNOOZED);
            for (int i = 0; i < NUM_ALARMS; i++)
                times_q[i] <= times_d[i];
        end
    end

    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_times
        assign alarm_times[g*TIME_W +: TIME_W] = times_q[g];
    end

    assign alarm_en    = en_q;
    assign ring_id     = id_q;
    assign snooze_left = left_q;

endmodule

// File: tb/tb_alarm_bank.sv
// Directed self-checking bench for alarm_bank.
// Vector table for slot writes/triggers plus hand sequences for timeouts and reset.
module tb_alarm_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick_1hz;
    logic [23:0] clock_time;
    logic        load_alarm;
    logic [1:0]  load_sel;
    logic        load_src;
    logic [23:0] load_value;
    logic        toggle_en;
    logic        snooze;
    logic        dismiss;
    logic [95:0] alarm_times;
    logic [3:0]  alarm_en;
    logic        ringing;
    logic        snoozed;
    logic [1:0]  ring_id;
    logic [1:0]  snooze_left;

    int passed = 0;
    int total  = 0;

    alarm_bank dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
        .clock_time(clock_time), .load_alarm(load_alarm),
        .load_sel(load_sel), .load_src(load_src),
        .load_value(load_value), .toggle_en(toggle_en),
        .snooze(snooze), .dismiss(dismiss),
        .alarm_times(alarm_times), .alarm_en(alarm_en),
        .ringing(ringing), .snoozed(snoozed),
        .ring_id(ring_id), .snooze_left(snooze_left)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        tk;
        logic [23:0] ct;
        logic        ld;
        logic [1:0]  sel;
        logic        src;
        logic [23:0] val;
        logic        tg;
        logic        sz;
        logic        dm;
        logic        er;
        logic        es;
        logic [1:0]  eid;
        logic [1:0]  el;
        logic [3:0]  een;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic chk_state(input string nm, input logic er, input logic es,
                             input logic [1:0] eid, input logic [1:0] el,
                             input logic [3:0] een);
        chk({nm, ".ringing"}, 32'(ringing), 32'(er));
        chk({nm, ".snoozed"}, 32'(snoozed), 32'(es));
        chk({nm, ".ring_id"}, 32'(ring_id), 32'(eid));
        chk({nm, ".snooze_left"}, 32'(snooze_left), 32'(el));
        chk({nm, ".alarm_en"}, 32'(alarm_en), 32'(een));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        tick_1hz   = 1'b0;
        load_alarm = 1'b0;
        toggle_en  = 1'b0;
        snooze     = 1'b0;
        dismiss    = 1'b0;
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            tick_1hz   = vt[i].tk;
            clock_time = vt[i].ct;
            load_alarm = vt[i].ld;
            load_sel   = vt[i].sel;
            load_src   = vt[i].src;
            load_value = vt[i].val;
            toggle_en  = vt[i].tg;
            snooze     = vt[i].sz;
            dismiss    = vt[i].dm;
            cyc();
            chk_state($sformatf("vec%0d", i), vt[i].er, vt[i].es,
                      vt[i].eid, vt[i].el, vt[i].een);
        end
    endtask

    initial begin
        //          tk ct        ld sel src val       tg sz dm er es id  lf  en
        vt[0]  = '{0, 24'h062959, 1, 2'd2, 1, 24'h063000, 0, 0, 0, 0, 0, 2'd0, 2'd3, 4'b0100};
        vt[1]  = '{0, 24'h062959, 0, 2'd0, 0, 24'h0,      0, 0, 0, 0, 0, 2'd0, 2'd3, 4'b0100};
        vt[2]  = '{0, 24'h063000, 0, 2'd0, 0, 24'h0,      0, 0, 0, 1, 0, 2'd2, 2'd3, 4'b0100};
        vt[3]  = '{0, 24'h063000, 1, 2'd1, 1, 24'h070000, 0, 0, 0, 0, 0, 2'd2, 2'd0, 4'b0110};
        vt[4]  = '{0, 24'h063000, 1, 2'd3, 1, 24'h070000, 0, 0, 0, 0, 0, 2'd2, 2'd0, 4'b1110};
        vt[5]  = '{0, 24'h063000, 1, 2'd0, 1, 24'h070001, 0, 0, 0, 0, 0, 2'd2, 2'd0, 4'b1111};
        vt[6]  = '{0, 24'h065959, 0, 2'd0, 0, 24'h0,      0, 0, 0, 0, 0, 2'd2, 2'd0, 4'b1111};
        vt[7]  = '{0, 24'h070000, 0, 2'd0, 0, 24'h0,      0, 0, 0, 1, 0, 2'd1, 2'd3, 4'b1111};
        vt[8]  = '{0, 24'h070001, 0, 2'd0, 0, 24'h0,      0, 0, 0, 1, 0, 2'd1, 2'd3, 4'b1111};
        vt[9]  = '{0, 24'h070001, 0, 2'd0, 0, 24'h0,      0, 1, 1, 0, 0, 2'd1, 2'd3, 4'b1111};
        vt[10] = '{0, 24'h070001, 0, 2'd0, 0, 24'h0,      1, 0, 0, 0, 0, 2'd1, 2'd3, 4'b1110};
        vt[11] = '{0, 24'h070001, 1, 2'd0, 0, 24'h0,      1, 0, 0, 0, 0, 2'd1, 2'd3, 4'b1111};
        vt[12] = '{0, 24'h070001, 0, 2'd0, 0, 24'h0,      0, 0, 0, 0, 0, 2'd1, 2'd3, 4'b1111};
        vt[13] = '{0, 24'h070000, 0, 2'd0, 0, 24'h0,      0, 0, 0, 1, 0, 2'd1, 2'd3, 4'b1111};
        vt[14] = '{0, 24'h070000, 0, 2'd0, 0, 24'h0,      0, 0, 1, 0, 0, 2'd1, 2'd3, 4'b1111};
        vt[15] = '{0, 24'h070000, 0, 2'd0, 0, 24'h0,      0, 0, 0, 0, 0, 2'd1, 2'd3, 4'b1111};

        rst_n = 1'b0;
        tick_1hz = 0; clock_time = '0; load_alarm = 0; load_sel = '0;
        load_src = 0; load_value = '0; toggle_en = 0; snooze = 0; dismiss = 0;
        #12;
        chk_state("reset", 0, 0, 2'd0, 2'd3, 4'b0000);
        chk("reset.times", alarm_times[31:0], 32'h0);
        rst_n = 1'b1;

        // Load slot 2 and trigger it.
        run_range(0, 2);
        chk("slot2.time", 32'(alarm_times[48 +: 24]), 32'h063000);

        // Auto-dismiss after 60 ticks; clock parked on the alarm time.
        for (int i = 1; i <= 60; i++) begin
            tick_1hz = 1'b1;
            cyc();
            if (i == 59) chk("ring.tick59", 32'(ringing), 32'd1);
            if (i == 60) chk("ring.tick60", 32'(ringing), 32'd0);
        end
        for (int i = 0; i < 3; i++) cyc();
        chk_state("no_retrigger", 0, 0, 2'd2, 2'd3, 4'b0100);

        // Snooze three times, fourth snooze dismisses.
        clock_time = 24'h062959; cyc();
        clock_time = 24'h063000; cyc();
        chk_state("retrigger", 1, 0, 2'd2, 2'd3, 4'b0100);
        for (int k = 1; k <= 3; k++) begin
            snooze = 1'b1;
            cyc();
            chk_state($sformatf("snooze%0d", k), 0, 1, 2'd2, 2'(3 - k), 4'b0100);
            for (int i = 1; i <= 540; i++) begin
                tick_1hz = 1'b1;
                cyc();
                if (i == 539) chk("snz.tick539", 32'(snoozed), 32'd1);
                if (i == 540) chk_state("snz.wake", 1, 0, 2'd2, 2'(3 - k), 4'b0100);
            end
        end
        snooze = 1'b1;
        cyc();
        chk_state("snooze4", 0, 0, 2'd2, 2'd0, 4'b0100);

        // Priority, ignored match, same-cycle events, plain dismiss.
        run_range(3, 15);
        chk("slot0.time", 32'(alarm_times[0 +: 24]), 32'h070001);

        // Reload while snoozed keeps state; toggle ring_id aborts.
        clock_time = 24'h070001; cyc();
        chk_state("trig0", 1, 0, 2'd0, 2'd3, 4'b1111);
        snooze = 1'b1; cyc();
        chk_state("snz0", 0, 1, 2'd0, 2'd2, 4'b1111);
        load_alarm = 1'b1; load_sel = 2'd0; load_src = 1'b1;
        load_value = 24'h070001; cyc();
        chk_state("reload", 0, 1, 2'd0, 2'd2, 4'b1111);
        toggle_en = 1'b1; load_sel = 2'd0; cyc();
        chk_state("tog_abort", 0, 0, 2'd0, 2'd2, 4'b1110);

        // Async reset mid-snooze.
        toggle_en = 1'b1; load_sel = 2'd0; cyc();
        clock_time = 24'h070002; cyc();
        clock_time = 24'h070001; cyc();
        snooze = 1'b1; cyc();
        chk_state("snz_again", 0, 1, 2'd0, 2'd2, 4'b1111);
        #3;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 0, 0, 2'd0, 2'd3, 4'b0000);
        chk("async_rst.times", 32'(alarm_times[0 +: 24]), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
Parametrised multi-slot alarm store and trigger controller. It replaces the single-register alarm capture stage. It holds NUM_ALARMS alarm times, each with its own enable. It detects when the running clock time reaches an enabled alarm, and runs a ring / snooze / dismiss state machine that drives the alarm output stage.

Parameters:
NUM_ALARMS, 4, number of alarm slots (1..16)
TIME_W, 24, clock/alarm time width (BCD HH:MM:SS, [23:20] hour tens .. [3:0] second units)
SEL_W, $clog2(NUM_ALARMS) min 1, slot index width (derived, not overridden)
SNOOZE_SEC, 540, snooze length in 1 Hz ticks
RING_SEC, 60, ring duration before auto-dismiss, in 1 Hz ticks
MAX_SNOOZE, 3, snoozes allowed per trigger; further snooze requests act as dismiss

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick_1hz  in  1  one-clk pulse per second, coincident with clock_time update
clock_time  in  TIME_W  current time from the total-time counter
load_alarm  in  1  pulse: write slot load_sel
load_sel  in  SEL_W  slot to write / toggle
load_src  in  1  0 = capture clock_time, 1 = capture load_value
load_value  in  TIME_W  explicit alarm time
toggle_en  in  1  pulse: invert enable of slot load_sel
snooze  in  1  pulse (debounced button)
dismiss  in  1  pulse (debounced button)
alarm_times  out  NUM_ALARMS*TIME_W  slot i at [i*TIME_W +: TIME_W]
alarm_en  out  NUM_ALARMS  per-slot enable
ringing  out  1  high while in RINGING
snoozed  out  1  high while in SNOOZED
ring_id  out  SEL_W  slot that caused the current trigger
snooze_left  out  $clog2(MAX_SNOOZE+1)  remaining snoozes

Behaviour:
- Reset (rst_n low, async): all alarm_times = 0, alarm_en = 0, state IDLE, ringing = snoozed = 0, ring_id = 0, snooze_left = MAX_SNOOZE, internal counters = 0, prev_time = 0.
- Writes: load_alarm writes the selected source into the slot at the next clk edge and sets that slot's enable to 1. toggle_en inverts the slot enable. If both pulse in the same cycle, the load wins and the enable ends at 1. load_sel >= NUM_ALARMS is ignored.
- Match detection: registered prev_time tracks clock_time every cycle. Slot i matches when alarm_en[i] = 1, clock_time == alarm_times[i], and clock_time != prev_time. A match therefore fires once per arrival, not for the whole second. A slot loaded with the current time does not fire until the next arrival.
- Match priority: the lowest index wins.
- Matches outside IDLE: ignored and not queued.
- FSM IDLE: on a match -> RINGING next cycle. ring_id = index, ring_cnt = 0, snooze_left = MAX_SNOOZE. Latency is 1 clk from the clock_time change to ringing = 1.
- FSM RINGING: ring_cnt increments on tick_1hz. The first matching condition below applies:
  - dismiss -> IDLE.
  - snooze with snooze_left > 0 -> SNOOZED, snooze_cnt = SNOOZE_SEC, snooze_left decrements.
  - snooze with snooze_left = 0 -> IDLE.
  - tick_1hz with ring_cnt == RING_SEC-1 -> IDLE (auto-dismiss).
- FSM SNOOZED: snooze_cnt decrements on tick_1hz. The first matching condition below applies:
  - dismiss -> IDLE.
  - tick_1hz with snooze_cnt == 1 -> RINGING, ring_cnt = 0.
  - snooze -> no effect.
- Simultaneous events: dismiss beats snooze, and both beat a tick timeout.
- Enable cleared mid-ring: if alarm_en[ring_id] is cleared (toggle) while RINGING or SNOOZED -> IDLE next cycle.
- Reload mid-ring: reloading slot ring_id without clearing its enable does not change the state.
- Outputs: ringing and snoozed are registered, decoded from state, and never both 1.
- Clock time jumps (user sets the clock): handled by the change-detect rule. Landing exactly on an alarm time triggers it.
- Counters are sized to hold SNOOZE_SEC and RING_SEC without wrap.
- No BCD arithmetic in this block.

Test Plan:
1. Reset then load slot 2 with load_src=1 and load_value=0x063000; step clock_time 0x062959 -> 0x063000 -> ringing=1 one clk later, ring_id=2, snooze_left=3.
2. Ringing, no input, 60 tick_1hz pulses -> ringing drops on the clk after the 60th tick; state IDLE. Clock held at 0x063000 for the whole second -> no re-trigger.
3. Ringing, snooze pulse -> snoozed=1, snooze_left=2. After 540 ticks ringing=1 again. Repeat snooze 3 times; a 4th snooze -> IDLE with snoozed=0.
4. Slots 1 and 3 both hold 0x070000 and are enabled; clock reaches 0x070000 -> ring_id=1. Slot 0 matches while ringing -> ignored, ring_id stays 1.
5. Same-cycle snooze+dismiss while ringing -> IDLE. Same-cycle load_alarm+toggle_en on slot 0 -> alarm_en[0]=1.
6. Toggle_en on ring_id while SNOOZED -> IDLE next clk. Assert rst_n low mid-SNOOZED, asynchronously between edges -> all outputs return to reset values immediately.
